subsurf_seq: RTL and testbench
==============================

SUBSURF_SEQ -- requirements
Module: subsurf_seq

Interface
REQ-001 Parameter NUM_ENG, default 3, number of engines run in phase order 0..NUM_ENG-1.
REQ-002 Parameter NUM_RAM, default 3, number of shared RAM ports.
REQ-003 Parameter ADDR_WIDTH, default 9, RAM address width.
REQ-004 Parameter DATA_WIDTH, default 32, RAM write-data width.
REQ-005 Parameter START_PULSE, default 2, engine start pulse length in cycles (>=1).
REQ-006 Parameter ITER_WIDTH, default 3, width of the subdivision-pass count.
REQ-007 Parameter TO_WIDTH, default 16, width of the per-phase timeout counter.
REQ-008 Clocking: one clock; reset is synchronous and active-high.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 start  in  1  begin a run; sampled only in IDLE.
REQ-012 iterations  in  ITER_WIDTH  passes to run; latched on accepted start; 0 treated as 1.
REQ-013 abort  in  1  terminate the current run.
REQ-014 eng_start  out  NUM_ENG  per-engine start pulse.
REQ-015 eng_busy  in  NUM_ENG  per-engine busy.
REQ-016 eng_en / eng_we / eng_a / eng_di  in  NUM_ENG*NUM_RAM*{1,4,ADDR_WIDTH,DATA_WIDTH}  flattened engine RAM requests, engine-major.
REQ-017 ram_en / ram_we / ram_a / ram_di  out  NUM_RAM*{1,4,ADDR_WIDTH,DATA_WIDTH}  muxed RAM port signals.
REQ-018 busy  out  1  high from accepted start through the final phase exit.
REQ-019 done  out  1  one-cycle pulse on normal completion.
REQ-020 error  out  1  sticky timeout/abort flag; cleared on next accepted start or rst.
REQ-021 phase  out  $clog2(NUM_ENG)  index of the active engine.
REQ-022 pass  out  ITER_WIDTH  zero-based index of the current pass.

Function
REQ-023 States: IDLE, PULSE, GUARD, WAIT, NEXT.
REQ-024 IDLE: start=1 -> latch iterations, clear error, phase=0, pass=0, busy=1, go to PULSE.
REQ-025 PULSE: eng_start[phase]=1 for exactly START_PULSE cycles, then GUARD; all other eng_start bits stay 0.
REQ-026 GUARD: one cycle with eng_start=0; eng_busy is ignored; then WAIT.
REQ-027 WAIT: eng_busy[phase]=0 -> NEXT; timeout counter increments each WAIT cycle, reset on entry.
REQ-028 Timeout: counter reaching 2^TO_WIDTH-1 with eng_busy[phase] still 1 -> error=1, busy=0, go to IDLE; no done.
REQ-029 NEXT: phase<NUM_ENG-1 -> phase+1, PULSE; else pass<iter-1 -> pass+1, phase=0, PULSE; else done=1, busy=0, IDLE.
REQ-030 Normal run length per phase: START_PULSE+1 cycles plus WAIT cycles plus 1 NEXT cycle.
REQ-031 RAM mux: in PULSE/GUARD/WAIT/NEXT, ram_* equals the eng_* slice of engine phase; in IDLE all ram_* = 0.
REQ-032 Mux is combinational from state and phase; no added latency on RAM signals.
REQ-033 abort=1 in any non-IDLE state -> next cycle IDLE, eng_start=0, busy=0, error=1, no done; abort in IDLE ignored.
REQ-034 abort and timeout in the same cycle: single error set, behaviour identical to abort.
REQ-035 start while busy=1 ignored; iterations changes after acceptance ignored.
REQ-036 Engine busy dropping during PULSE/GUARD does not advance the phase early.

Reset
REQ-037 rst=1 at any clock edge -> state IDLE, phase=0, pass=0, timeout counter 0.
REQ-038 Outputs during/after reset: eng_start=0, busy=0, done=0, error=0, all ram_*=0.
REQ-039 rst mid-run abandons the run without done or error; rst has priority over start and abort.

Verification
REQ-040 Defaults, iterations=1, each engine busy 5 cycles after GUARD -> eng_start 0,1,2 pulses 2 cycles each in order, single done, busy low same cycle as done.
REQ-041 iterations=2 -> six phases 0,1,2,0,1,2, pass 0 then 1, exactly one done; iterations=0 behaves as 1.
REQ-042 TO_WIDTH=4, engine 1 holds busy -> error=1 after 15 WAIT cycles, busy=0, no done, ram_*=0 next cycle.
REQ-043 abort asserted in WAIT of phase 2 -> IDLE next cycle, error=1; subsequent start clears error and runs normally.
REQ-044 Distinct eng_a per engine (0x011,0x022,0x033 on port 0) -> ram_a port 0 follows active phase; 0 in IDLE.
REQ-045 rst pulsed during phase 1 PULSE -> all outputs reset values next cycle, no done, no error.

Source files
------------

// File: rtl/subsurf_seq.sv
// subsurf_seq -- sequences a chain of subdivision engines.
//
// Runs engines 0..NUM_ENG-1 in phase order, repeated for `iterations` passes.
// Each phase follows the same pattern: a start pulse, one guard cycle, then a
// wait for the engine's busy to drop. A per-phase timeout or an abort ends the
// run early and sets a sticky error. While a run is active, the shared RAM
// ports follow the active engine's request slice.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, iterations run request; pass count is latched on accept (0 -> 1)
//   abort             ends the current run with error
//   eng_start         per-engine start pulse (registered)
//   eng_busy          per-engine busy
//   eng_en/we/a/di    flattened engine RAM requests, engine-major
//   ram_en/we/a/di    RAM ports muxed from the active engine (0 in IDLE)
//   busy, done, error run status; done is a one-cycle pulse, error is sticky
//   phase, pass       active engine index and zero-based pass index
module subsurf_seq #(
   parameter int NUM_ENG     = 3,
   parameter int NUM_RAM     = 3,
   parameter int ADDR_WIDTH  = 9,
   parameter int DATA_WIDTH  = 32,
   parameter int START_PULSE = 2,
   parameter int ITER_WIDTH  = 3,
   parameter int TO_WIDTH    = 16,
   localparam int PW         = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start,
   input  logic [ITER_WIDTH-1:0]                      iterations,
   input  logic                                       abort,
   output logic [NUM_ENG-1:0]                         eng_start,
   input  logic [NUM_ENG-1:0]                         eng_busy,
   input  logic [NUM_ENG*NUM_RAM-1:0]                 eng_en,
   input  logic [NUM_ENG*NUM_RAM*4-1:0]               eng_we,
   input  logic [NUM_ENG*NUM_RAM*ADDR_WIDTH-1:0]      eng_a,
   input  logic [NUM_ENG*NUM_RAM*DATA_WIDTH-1:0]      eng_di,
   output logic [NUM_RAM-1:0]                         ram_en,
   output logic [NUM_RAM*4-1:0]                       ram_we,
   output logic [NUM_RAM*ADDR_WIDTH-1:0]              ram_a,
   output logic [NUM_RAM*DATA_WIDTH-1:0]              ram_di,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       error,
   output logic [PW-1:0]                              phase,
   output logic [ITER_WIDTH-1:0]                      pass
);

   localparam int PCW = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
   localparam logic [PCW-1:0]      P_LAST  = PCW'(START_PULSE - 1);
   // The timeout fires on the WAIT cycle that would bring the counter to all-ones.
   localparam logic [TO_WIDTH-1:0] TO_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [PW-1:0]       PH_LAST = PW'(NUM_ENG - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_GUARD,
      S_WAIT,
      S_NEXT
   } state_t;

   state_t                state;
   logic [PCW-1:0]        pcnt;
   logic [TO_WIDTH-1:0]   to_cnt;
   logic [ITER_WIDTH-1:0] iter_lat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         phase     <= '0;
         pass      <= '0;
         pcnt      <= '0;
         to_cnt    <= '0;
         iter_lat  <= '0;
         eng_start <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         done <= 1'b0;
         // Abort outranks every in-run transition, including a coincident timeout.
         if (state != S_IDLE && abort) begin
            state     <= S_IDLE;
            eng_start <= '0;
            busy      <= 1'b0;
            error     <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     iter_lat  <= (iterations == '0) ? ITER_WIDTH'(1) : iterations;
                     error     <= 1'b0;
                     phase     <= '0;
                     pass      <= '0;
                     pcnt      <= '0;
                     busy      <= 1'b1;
                     eng_start <= NUM_ENG'(1);
                     state     <= S_PULSE;
                  end
               end
               S_PULSE: begin
                  if (pcnt == P_LAST) begin
                     eng_start <= '0;
                     state     <= S_GUARD;
                  end else begin
                     pcnt <= pcnt + 1'b1;
                  end
               end
               S_GUARD: begin
                  to_cnt <= '0;
                  state  <= S_WAIT;
               end
               S_WAIT: begin
                  if (!eng_busy[phase]) begin
                     state <= S_NEXT;
                  end else if (to_cnt == TO_LAST) begin
                     error <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
               S_NEXT: begin
                  pcnt <= '0;
                  if (phase != PH_LAST) begin
                     phase     <= phase + 1'b1;
                     eng_start <= NUM_ENG'(1) << (phase + 1'b1);
                     state     <= S_PULSE;
                  end else if (pass != iter_lat - 1'b1) begin
                     pass      <= pass + 1'b1;
                     phase     <= '0;
                     eng_start <= NUM_ENG'(1);
                     state     <= S_PULSE;
                  end else begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // RAM ports follow the active engine with no register stage.
   always_comb begin
      ram_en = '0;
      ram_we = '0;
      ram_a  = '0;
      ram_di = '0;
      if (state != S_IDLE) begin
         for (int unsigned e = 0; e < NUM_ENG; e++) begin
            if (phase == PW'(e)) begin
               ram_en = eng_en[e*NUM_RAM +: NUM_RAM];
               ram_we = eng_we[e*NUM_RAM*4 +: NUM_RAM*4];
               ram_a  = eng_a[e*NUM_RAM*ADDR_WIDTH +: NUM_RAM*ADDR_WIDTH];
               ram_di = eng_di[e*NUM_RAM*DATA_WIDTH +: NUM_RAM*DATA_WIDTH];
            end
         end
      end
   end

endmodule

// File: tb/tb_subsurf_seq.sv
// Scoreboard bench for subsurf_seq: stimulus pushes the expected event stream
// (engine start rises, done, error rise) and a monitor pops and compares.
module tb_subsurf_seq;

   localparam int NE = 3;
   localparam int NR = 3;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int SP = 2;
   localparam int IW = 3;
   localparam int TW = 4;
   localparam int PW = 2;

   localparam int K_START = 0;
   localparam int K_DONE  = 1;
   localparam int K_ERR   = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [IW-1:0]      iterations;
   logic               abort;
   logic [NE-1:0]      eng_start;
   logic [NE-1:0]      eng_busy;
   logic [NE*NR-1:0]   eng_en;
   logic [NE*NR*4-1:0] eng_we;
   logic [NE*NR*AW-1:0] eng_a;
   logic [NE*NR*DW-1:0] eng_di;
   logic [NR-1:0]      ram_en;
   logic [NR*4-1:0]    ram_we;
   logic [NR*AW-1:0]   ram_a;
   logic [NR*DW-1:0]   ram_di;
   logic               busy, done, error;
   logic [PW-1:0]      phase;
   logic [IW-1:0]      pass;

   subsurf_seq #(
      .NUM_ENG(NE), .NUM_RAM(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .START_PULSE(SP), .ITER_WIDTH(IW), .TO_WIDTH(TW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .iterations(iterations), .abort(abort),
      .eng_start(eng_start), .eng_busy(eng_busy),
      .eng_en(eng_en), .eng_we(eng_we), .eng_a(eng_a), .eng_di(eng_di),
      .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
      .busy(busy), .done(done), .error(error), .phase(phase), .pass(pass)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int eng;
      int pss;
      int dly;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;

   // Engine model: busy from the start pulse until hold[e] cycles after it.
   int  hold [NE];
   int  cnt  [NE];
   bit  clr = 1'b0;

   // Port-0 addresses per engine, other fields by formula.
   logic [AW-1:0] a0 [NE];

   function automatic logic [DW-1:0] di_of(int e, int r);
      return 32'hA500_0000 | DW'(e << 8) | DW'(r);
   endfunction

   function automatic logic [NR-1:0] en_of(int e);
      logic [NR-1:0] v;
      for (int r = 0; r < NR; r++) v[r] = ((e + r) % 2) == 0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input int e, input int p, input int d);
      ev_t ev;
      ev.kind = kind; ev.eng = e; ev.pss = p; ev.dly = d;
      q.push_back(ev);
   endtask

   // Engine model
   initial begin
      eng_busy = '0;
      for (int e = 0; e < NE; e++) cnt[e] = 0;
      forever begin
         @(negedge clk);
         for (int e = 0; e < NE; e++) begin
            if (clr) cnt[e] = 0;
            else if (eng_start[e]) cnt[e] = hold[e];
            else if (cnt[e] > 0) cnt[e] = cnt[e] - 1;
            eng_busy[e] = (cnt[e] != 0);
         end
      end
   end

   // Monitor
   initial begin
      logic [NE-1:0] prev_st;
      logic          prev_err;
      int            run_len;
      int            since_fall;
      ev_t           ev;
      prev_st = '0; prev_err = 1'b0; run_len = 0; since_fall = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_st = '0; prev_err = 1'b0; run_len = 0; since_fall = 0;
            continue;
         end
         since_fall++;
         if (eng_start != '0) begin
            if (prev_st == '0) begin
               run_len = 1;
               if (q.size() == 0) begin
                  chk("unexpected_start", 64'(eng_start), 64'(0));
               end else begin
                  ev = q.pop_front();
                  chk("start_kind", 64'(K_START), 64'(ev.kind));
                  chk("start_onehot", 64'(eng_start), 64'(1 << ev.eng));
                  chk("start_phase", 64'(phase), 64'(ev.eng));
                  chk("start_pass", 64'(pass), 64'(ev.pss));
                  chk("ram_a_port0", 64'(ram_a[AW-1:0]), 64'(a0[ev.eng]));
                  chk("ram_di_port2", 64'(ram_di[2*DW +: DW]), 64'(di_of(ev.eng, 2)));
                  chk("ram_en", 64'(ram_en), 64'(en_of(ev.eng)));
                  if (ev.dly >= 0) chk("start_gap", 64'(since_fall), 64'(ev.dly));
               end
            end else begin
               run_len++;
            end
         end else if (prev_st != '0) begin
            chk("pulse_len", 64'(run_len), 64'(SP));
            since_fall = 0;
         end
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 64'(done), 64'(0));
            end else begin
               ev = q.pop_front();
               chk("done_kind", 64'(K_DONE), 64'(ev.kind));
               chk("done_busy", 64'(busy), 64'(0));
               chk("done_ram_a", 64'(ram_a), 64'(0));
               if (ev.dly >= 0) chk("done_gap", 64'(since_fall), 64'(ev.dly));
            end
         end
         if (error && !prev_err) begin
            if (q.size() == 0) begin
               chk("unexpected_error", 64'(error), 64'(0));
            end else begin
               ev = q.pop_front();
               chk("err_kind", 64'(K_ERR), 64'(ev.kind));
               chk("err_busy", 64'(busy), 64'(0));
               chk("err_ram_zero", {ram_en, ram_a}, 64'(0));
               chk("err_start_zero", 64'(eng_start), 64'(0));
               if (ev.dly >= 0) chk("err_gap", 64'(since_fall), 64'(ev.dly));
            end
         end
         prev_st  = eng_start;
         prev_err = error;
      end
   end

   task automatic go(input logic [IW-1:0] it);
      @(negedge clk);
      iterations = it;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      iterations = 3'd7;
      chk("busy_after_start", 64'(busy), 64'(1));
      chk("error_cleared", 64'(error), 64'(0));
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) @(negedge clk);
      chk("wait_idle", 64'(busy), 64'(0));
      @(negedge clk);
      @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'(0));
   endtask

   task automatic push_run(input int passes);
      for (int p = 0; p < passes; p++)
         for (int e = 0; e < NE; e++)
            push(K_START, e, p, (p == 0 && e == 0) ? -1 : 8);
      push(K_DONE, 0, 0, 8);
   endtask

   task automatic clear_engines();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); @(negedge clk); clr = 1'b0;
      for (int e = 0; e < NE; e++) hold[e] = 7;
   endtask

   initial begin
      a0[0] = 9'h011; a0[1] = 9'h022; a0[2] = 9'h033;
      for (int e = 0; e < NE; e++) begin
         hold[e] = 7;
         for (int r = 0; r < NR; r++) begin
            eng_a[(e*NR + r)*AW +: AW]  = (r == 0) ? a0[e] : AW'(9'h100 + e*16 + r);
            eng_di[(e*NR + r)*DW +: DW] = di_of(e, r);
            eng_we[(e*NR + r)*4 +: 4]   = 4'(e + r + 1);
         end
         eng_en[e*NR +: NR] = en_of(e);
      end
      rst = 1'b1; start = 1'b0; abort = 1'b0; iterations = '0;
      repeat (3) @(negedge clk);
      chk("rst_state", {eng_start, busy, done, error, phase, pass}, 64'(0));
      chk("rst_ram", {ram_en, ram_we, ram_a}, 64'(0));
      chk("rst_ram_di", 64'(ram_di[63:0]), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single pass, each engine busy 5 WAIT cycles
      push_run(1);
      go(3'd1);
      wait_idle(200);
      chk("idle_ram_a", 64'(ram_a), 64'(0));
      chk("idle_ram_en", 64'(ram_en), 64'(0));

      // Two passes; a start mid-run must be ignored
      push_run(2);
      go(3'd2);
      repeat (10) @(negedge clk);
      start = 1'b1; iterations = 3'd5;
      @(negedge clk);
      start = 1'b0;
      wait_idle(300);

      // iterations=0 runs once
      push_run(1);
      go(3'd0);
      wait_idle(200);

      // Timeout: engine 1 never drops busy
      hold[1] = 1000;
      push(K_START, 0, 0, -1);
      push(K_START, 1, 0, 8);
      push(K_ERR, 0, 0, 16);
      go(3'd1);
      wait_idle(200);
      chk("timeout_error_sticky", 64'(error), 64'(1));
      clear_engines();

      // Abort in WAIT of phase 2, then a clean rerun
      push(K_START, 0, 0, -1);
      push(K_START, 1, 0, 8);
      push(K_START, 2, 0, 8);
      push(K_ERR, 0, 0, -1);
      go(3'd1);
      for (int i = 0; i < 100 && !eng_start[2]; i++) @(negedge clk);
      chk("reach_phase2", 64'(eng_start[2]), 64'(1));
      for (int i = 0; i < 10 && eng_start != '0; i++) @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_error", 64'(error), 64'(1));
      chk("abort_ram_a", 64'(ram_a), 64'(0));
      wait_idle(10);
      push_run(1);
      go(3'd1);
      wait_idle(200);
      chk("rerun_error", 64'(error), 64'(0));

      // Reset during phase 1 PULSE
      push(K_START, 0, 0, -1);
      push(K_START, 1, 0, 8);
      go(3'd1);
      for (int i = 0; i < 100 && !eng_start[1]; i++) @(negedge clk);
      chk("reach_phase1", 64'(eng_start[1]), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_state", {eng_start, busy, done, error, phase, pass}, 64'(0));
      chk("midrst_ram", {ram_en, ram_we, ram_a}, 64'(0));
      @(negedge clk);
      rst = 1'b0;
      clear_engines();
      repeat (30) @(negedge clk);
      chk("midrst_quiet", {busy, done, error}, 64'(0));
      chk("midrst_queue", 64'(q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
